// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor with a carry-save-free sliced carry chain.
// One slice of the sum per stage, valid/ready handshake with global stall.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_addsub: bad WIDTH/STAGES");
  end

  logic [STAGES-1:0]            v_r;
  logic [STAGES-1:0]            v_in;
  logic [STAGES-1:0]            c_r;
  logic [STAGES-1:0]            c_in;
  logic [STAGES-1:0]            c_nx;
  logic [STAGES-1:0][WIDTH-1:0] a_r;
  logic [STAGES-1:0][WIDTH-1:0] b_r;
  logic [STAGES-1:0][WIDTH-1:0] s_r;
  logic [STAGES-1:0][WIDTH-1:0] a_in;
  logic [STAGES-1:0][WIDTH-1:0] b_in;
  logic [STAGES-1:0][WIDTH-1:0] s_in;
  logic [STAGES-1:0][WIDTH-1:0] s_nx;
  logic [STAGES-1:0][SLICE:0]   slc;
  logic                         ovf_r;
  logic                         zero_r;
  logic                         ovf_nx;
  logic                         zero_nx;
  logic                         stall;
  logic                         unused_ok;

  assign stall     = v_r[L] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_r[L];
  assign sum       = s_r[L];
  assign cout      = c_r[L];
  assign ovf       = ovf_r;
  assign zero      = zero_r;

  // Already-consumed low operand slices are carried but never read.
  assign unused_ok = ^{a_r, b_r};

  // Stage inputs: ports feed stage 0, each later stage takes its predecessor.
  always_comb begin
    v_in    = '0;
    c_in    = '0;
    a_in    = '0;
    b_in    = '0;
    s_in    = '0;
    v_in[0] = in_valid;
    a_in[0] = a;
    b_in[0] = op_sub ? ~b : b;
    s_in[0] = '0;
    c_in[0] = op_sub;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_r[k-1];
      a_in[k] = a_r[k-1];
      b_in[k] = b_r[k-1];
      s_in[k] = s_r[k-1];
      c_in[k] = c_r[k-1];
    end
  end

  // Stage k adds its own slice and forwards everything else untouched.
  always_comb begin
    s_nx = s_in;
    c_nx = '0;
    slc  = '0;
    for (int k = 0; k < STAGES; k++) begin
      slc[k] = {1'b0, a_in[k][k*SLICE +: SLICE]}
             + {1'b0, b_in[k][k*SLICE +: SLICE]}
             + {{SLICE{1'b0}}, c_in[k]};
      s_nx[k][k*SLICE +: SLICE] = slc[k][SLICE-1:0];
      c_nx[k] = slc[k][SLICE];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  always_comb begin
    ovf_nx  = a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1]
            ^ s_nx[L][WIDTH-1] ^ c_nx[L];
    zero_nx = ~|s_nx[L];
  end

  // Whole pipe advances together unless the final beat is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r    <= '0;
      c_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (!stall) begin
      v_r    <= v_in;
      c_r    <= c_nx;
      a_r    <= a_in;
      b_r    <= b_in;
      s_r    <= s_nx;
      ovf_r  <= ovf_nx;
      zero_r <= zero_nx;
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed literals, streaming, backpressure,
// reset flush and random traffic against a queue-based reference model.
module tb_pipe_addsub;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 0;
  logic         rst_n = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op_sub = 0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  logic mon_en = 0;
  logic prev_stall = 0;
  res_t prev;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic sub);
    res_t r;
    longint unsigned ux, uy, full;
    ux = 64'(x);
    uy = 64'(y);
    full = sub ? (ux + (64'd1 << W) - uy) : (ux + uy);
    r.s = full[W-1:0];
    r.c = full[W];
    if (sub)
      r.o = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    else
      r.o = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    r.z = (r.s == '0);
    return r;
  endfunction

  // Compare process: everything that crosses the next edge is stable here.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall)
        chk("frozen", 64'({out_valid, sum, cout, ovf, zero}),
            64'({1'b1, prev}));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          chk("result", 64'({sum, cout, ovf, zero}), 64'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, op_sub));
      prev_stall = out_valid && !out_ready;
      prev = '{s: sum, c: cout, o: ovf, z: zero};
    end else begin
      prev_stall = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, input res_t e, input string n);
    tick();
    a = x; b = y; op_sub = sub; in_valid = 1;
    chk({n, "_in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 0;
    repeat (2) tick();
    chk({n, "_early"}, 64'(out_valid), 64'(0));
    tick();
    chk({n, "_valid"}, 64'(out_valid), 64'(1));
    chk({n, "_sum"}, 64'(sum), 64'(e.s));
    chk({n, "_cout"}, 64'(cout), 64'(e.c));
    chk({n, "_ovf"}, 64'(ovf), 64'(e.o));
    chk({n, "_zero"}, 64'(zero), 64'(e.z));
    tick();
  endtask

  task automatic rand_beat();
    a = $urandom();
    b = $urandom();
    op_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string n);
    int t;
    in_valid = 0;
    out_ready = 1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk({n, "_drained"}, 64'(q.size()), 64'(0));
  endtask

  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outs", 64'({sum, cout, ovf, zero}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mon_en = 1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Literal expectations that also pin the model.
    chk("model_pin", 64'(model(32'h7FFFFFFF, 32'h1, 0)),
        64'({32'h80000000, 1'b0, 1'b1, 1'b0}));
    send_one(32'hFFFFFFFF, 32'h1, 0,
             '{s: 32'h0, c: 1'b1, o: 1'b0, z: 1'b1}, "carry_chain");
    send_one(32'h7FFFFFFF, 32'h1, 0,
             '{s: 32'h80000000, c: 1'b0, o: 1'b1, z: 1'b0}, "ovf_add");
    send_one(32'h80000000, 32'h1, 1,
             '{s: 32'h7FFFFFFF, c: 1'b1, o: 1'b1, z: 1'b0}, "ovf_sub");
    send_one(32'h5, 32'h5, 1,
             '{s: 32'h0, c: 1'b1, o: 1'b0, z: 1'b1}, "sub_zero");
    send_one(32'h0, 32'h1, 1,
             '{s: 32'hFFFFFFFF, c: 1'b0, o: 1'b0, z: 1'b0}, "borrow");
    drain("directed");

    // Back-to-back stream of 16: results on 16 consecutive cycles.
    for (int j = 0; j < 20; j++) begin
      if (j < 16) begin
        rand_beat();
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      tick();
      chk("stream_valid", 64'(out_valid), 64'(j >= 3 && j <= 18));
    end
    drain("stream");

    // Backpressure with a full pipe; inputs keep being offered.
    for (int j = 0; j < 4; j++) begin
      rand_beat();
      in_valid = 1;
      tick();
    end
    out_ready = 0;
    for (int j = 0; j < 5; j++) begin
      rand_beat();
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1;
    drain("backpressure");

    // Reset with the output valid and three beats behind it.
    for (int j = 0; j < 4; j++) begin
      rand_beat();
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_outs", 64'({sum, cout, ovf, zero}), 64'(0));
    q.delete();
    tick();
    tick();
    rst_n = 1;
    chk("rel_in_ready", 64'(in_ready), 64'(1));
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("post_rst_quiet", 64'(out_valid), 64'(0));
    end
    send_one(32'h12345678, 32'h11111111, 0,
             '{s: 32'h23456789, c: 1'b0, o: 1'b0, z: 1'b0}, "after_rst");

    // Random traffic with random backpressure.
    for (int j = 0; j < 400; j++) begin
      rand_beat();
      if ($urandom_range(0, 9) == 0) b = a;
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, minimum 2.
REQ-002 Parameter STAGES, default 4: pipeline depth, 1..WIDTH; WIDTH SHALL be an integer multiple of STAGES (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts operand beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result beat.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout  output  1  raw carry out of MSB (for subtract: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  sum equals 0.

Function
REQ-016 Datapath SHALL be split into STAGES slices of SLICE = WIDTH/STAGES bits; stage k adds slice k (bits k*SLICE .. k*SLICE+SLICE-1) using the carry registered by stage k-1.
REQ-017 Stage 0 carry-in SHALL be op_sub; B SHALL be bitwise inverted when op_sub = 1.
REQ-018 Unprocessed upper operand slices and completed lower sum slices SHALL be carried forward in pipeline registers (skew/deskew) so all WIDTH result bits emerge together.
REQ-019 Each stage SHALL hold a valid bit; a beat accepted at edge N SHALL appear with out_valid = 1 after edge N+STAGES-1 when no stall occurs (latency STAGES cycles, throughput one beat per cycle).
REQ-020 Transfer on input SHALL occur when in_valid && in_ready; on output when out_valid && out_ready.
REQ-021 stall = out_valid && !out_ready; while stall = 1 all pipeline registers SHALL hold and in_ready SHALL be 0.
REQ-022 in_ready SHALL be !stall (combinational); out_ready SHALL NOT be required to be stable.
REQ-023 Empty stages (valid = 0) SHALL not block: a bubble SHALL advance even when downstream stages hold data, provided stall = 0.
REQ-024 ovf SHALL equal carry into MSB XOR carry out of MSB of the effective addition (A + B' + cin).
REQ-025 zero, ovf, cout, sum SHALL be registered with the final stage and held stable while out_valid = 1 and out_ready = 0.
REQ-026 Outputs sum, cout, ovf, zero are don't-care when out_valid = 0.
REQ-027 With STAGES = 1 the block SHALL be a single registered adder with latency 1 and identical handshake rules.

Reset
REQ-028 rst_n = 0 SHALL immediately clear every stage valid bit; out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0 while held.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none SHALL emerge after release.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-031 Datapath registers other than valid bits and outputs MAY be left unreset.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-032 Add with full carry chain: a=0xFFFFFFFF, b=0x00000001, op_sub=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0, zero=1.
REQ-033 Signed overflow: a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x00000001, sub -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-034 Back-to-back stream of 16 random beats with in_valid=1 each cycle -> 16 results in order on consecutive cycles, each matching reference model.
REQ-035 Backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs frozen, no beat lost or duplicated after out_ready returns to 1.
REQ-036 Reset with 3 beats in flight -> out_valid=0 immediately, no result appears after release, next accepted beat emerges after exactly 4 cycles.
